// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: counts accepted samples, selects the
// butterfly mode, addresses the twiddle ROM and drains the delay line on flush.
module fft_sdf_stage_ctrl #(
  parameter int unsigned DELAY = 128,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned FRM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] tw_addr,
  output logic             tw_en,
  output logic             out_valid,
  output logic             frame_done,
  output logic [FRM_W-1:0] frame_cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DELAY - 1);

  typedef enum logic [1:0] {
    StFill  = 2'd0,
    StBfly  = 2'd1,
    StTwid  = 2'd2,
    StFlush = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             accept;
  logic             cnt_last;

  assign cnt_last  = (cnt_q == CntMax);
  assign frame_cnt = frame_cnt_q;
  assign busy      = !((state_q == StFill) && (cnt_q == '0));

  // Next-state decode and zero-latency output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q | flush;
    in_ready     = (state_q != StFlush);
    accept       = in_valid & in_ready;
    phase        = 2'd0;
    tw_addr      = '0;
    tw_en        = 1'b0;
    out_valid    = 1'b0;
    frame_done   = 1'b0;

    unique case (state_q)
      StFill: begin
        // Nothing in flight yet, so there is nothing to drain.
        if (cnt_q == '0) flush_pend_d = 1'b0;
        if (accept) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = StBfly;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StBfly: begin
        phase     = 2'd1;
        out_valid = accept;
        if (accept) begin
          if (cnt_last) begin
            cnt_d = '0;
            if (flush_pend_q | flush) begin
              state_d      = StFlush;
              flush_pend_d = 1'b0;
            end else begin
              state_d = StTwid;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StTwid: begin
        phase     = 2'd2;
        tw_en     = 1'b1;
        tw_addr   = cnt_q;
        out_valid = accept;
        if (accept) begin
          if (cnt_last) begin
            frame_done = 1'b1;
            cnt_d      = '0;
            state_d    = StBfly;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StFlush: begin
        // Self-timed drain: advances every cycle regardless of in_valid.
        phase     = 2'd2;
        tw_en     = 1'b1;
        tw_addr   = cnt_q;
        out_valid = 1'b1;
        if (cnt_last) begin
          frame_done   = 1'b1;
          flush_pend_d = 1'b0;
          cnt_d        = '0;
          state_d      = StFill;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    frame_cnt_d = frame_done ? frame_cnt_q + FRM_W'(1) : frame_cnt_q;
  end

  // State, counters and pending-flush flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFill;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Self-checking bench for fft_sdf_stage_ctrl at D=128 and D=4.
module tb_fft_sdf_stage_ctrl;

  typedef struct {
    int         iv;
    int         fl;
    logic [1:0] ph;
    logic       ir;
    logic       ov;
    logic [7:0] ta;
    logic       ct;
    logic       fd;
    logic       bz;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, flush, sel4;

  logic [1:0]  ph128, ph4;
  logic [6:0]  ta128;
  logic [1:0]  ta4;
  logic        ir128, ir4, te128, te4, ov128, ov4, fd128, fd4, bz128, bz4;
  logic [15:0] fc128, fc4;

  logic [1:0]  o_phase;
  logic [7:0]  o_ta;
  logic        o_ir, o_te, o_ov, o_fd, o_bz;
  logic [15:0] o_fc;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc_n = 0;
  logic [15:0] fc_model = 16'd0;
  exp_t        sb[$];
  exp_t        ftab[$];

  always #5 clk = ~clk;

  fft_sdf_stage_ctrl #(.DELAY(128), .CNT_W(7), .FRM_W(16)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir128), .flush(flush),
    .phase(ph128), .tw_addr(ta128), .tw_en(te128), .out_valid(ov128),
    .frame_done(fd128), .frame_cnt(fc128), .busy(bz128)
  );

  fft_sdf_stage_ctrl #(.DELAY(4), .CNT_W(2), .FRM_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .flush(flush),
    .phase(ph4), .tw_addr(ta4), .tw_en(te4), .out_valid(ov4),
    .frame_done(fd4), .frame_cnt(fc4), .busy(bz4)
  );

  assign o_phase = sel4 ? ph4 : ph128;
  assign o_ta    = sel4 ? {6'd0, ta4} : {1'b0, ta128};
  assign o_ir    = sel4 ? ir4 : ir128;
  assign o_te    = sel4 ? te4 : te128;
  assign o_ov    = sel4 ? ov4 : ov128;
  assign o_fd    = sel4 ? fd4 : fd128;
  assign o_bz    = sel4 ? bz4 : bz128;
  assign o_fc    = sel4 ? fc4 : fc128;

  task automatic chk(input string nm, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d D=%0d got=%0d want=%0d", nm, cyc_n, sel4 ? 4 : 128, act, want);
    end
  endtask

  task automatic compare(input exp_t e);
    chk("phase", int'(o_phase), int'(e.ph));
    chk("in_ready", int'(o_ir), int'(e.ir));
    chk("out_valid", int'(o_ov), int'(e.ov));
    chk("tw_en", int'(o_te), int'(e.ph == 2'd2));
    if (e.ct) chk("tw_addr", int'(o_ta), int'(e.ta));
    chk("frame_done", int'(o_fd), int'(e.fd));
    chk("busy", int'(o_bz), int'(e.bz));
    chk("frame_cnt", int'(o_fc), int'(e.fc));
  endtask

  function automatic exp_t row(input int iv, input int fl, input int ph, input int ir,
                               input int ov, input int ta, input int fd, input int bz);
    exp_t e;
    e.iv = iv;
    e.fl = fl;
    e.ph = 2'(ph);
    e.ir = 1'(ir);
    e.ov = 1'(ov);
    e.ta = 8'(ta);
    e.ct = (ph == 2);
    e.fd = 1'(fd);
    e.bz = 1'(bz);
    e.fc = 16'd0;
    return e;
  endfunction

  // Expected outputs for the a-th accepted sample of an unflushed stream
  // (acc=0: idle cycle while waiting for that sample).
  function automatic exp_t stream_exp(input int a, input int acc, input int d);
    int j, seg;
    if (a < d) return row(acc, 0, 0, 1, 0, 0, 0, (a != 0) ? 1 : 0);
    j   = a - d;
    seg = (j / d) % 2;
    return row(acc, 0, seg ? 2 : 1, 1, acc, j % d,
               (acc != 0 && seg != 0 && (j % d) == d - 1) ? 1 : 0, 1);
  endfunction

  // Push expectation on drive, pop and compare mid-cycle.
  task automatic drive(input exp_t e);
    exp_t got;
    in_valid = 1'(e.iv);
    flush    = 1'(e.fl);
    e.fc     = fc_model;
    if (e.fd) fc_model = fc_model + 16'd1;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    compare(got);
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    rst_n    = 1'b0;
    fc_model = 16'd0;
    for (int i = 0; i < 5; i++) begin
      e    = row(1, 0, 0, 1, 0, 0, 0, 0);
      e.ct = 1'b1;
      drive(e);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    sel4     = 1'b0;

    // Flush/idle-flush/deferred-flush sequence at D=4.
    for (int i = 0; i < 4; i++) ftab.push_back(row(1, 0, 0, 1, 0, 0, 0, i != 0));
    ftab.push_back(row(1, 0, 1, 1, 1, 0, 0, 1));
    ftab.push_back(row(1, 0, 1, 1, 1, 0, 0, 1));
    ftab.push_back(row(1, 1, 1, 1, 1, 0, 0, 1));   // flush at BFLY cnt=2
    ftab.push_back(row(1, 0, 1, 1, 1, 0, 0, 1));
    for (int i = 0; i < 4; i++) ftab.push_back(row(1, 0, 2, 0, 1, i, i == 3, 1));
    ftab.push_back(row(0, 0, 0, 1, 0, 0, 0, 0));
    ftab.push_back(row(0, 1, 0, 1, 0, 0, 0, 0));   // flush while idle: dropped
    for (int i = 0; i < 4; i++) ftab.push_back(row(1, 0, 0, 1, 0, 0, 0, i != 0));
    for (int i = 0; i < 4; i++) ftab.push_back(row(1, 0, 1, 1, 1, 0, 0, 1));
    ftab.push_back(row(1, 0, 2, 1, 1, 0, 0, 1));   // TWID, not FLUSH
    ftab.push_back(row(1, 1, 2, 1, 1, 1, 0, 1));   // flush in TWID: deferred
    ftab.push_back(row(1, 0, 2, 1, 1, 2, 0, 1));
    ftab.push_back(row(1, 0, 2, 1, 1, 3, 1, 1));
    for (int i = 0; i < 4; i++) ftab.push_back(row(1, 0, 1, 1, 1, 0, 0, 1));
    for (int i = 0; i < 4; i++) ftab.push_back(row(0, 0, 2, 0, 1, i, i == 3, 1));
    ftab.push_back(row(0, 0, 0, 1, 0, 0, 0, 0));

    @(posedge clk);
    #1;

    // Reset with in_valid high, then one full D=128 frame.
    do_reset();
    for (int a = 0; a < 384; a++) drive(stream_exp(a, 1, 128));
    drive(stream_exp(384, 0, 128));

    // D=4 continuous stream.
    sel4 = 1'b1;
    do_reset();
    for (int a = 0; a < 24; a++) drive(stream_exp(a, 1, 4));

    // D=4 gapped stream: idle cycles hold phase and tw_addr.
    do_reset();
    begin
      int a = 0;
      for (int t = 0; t < 24; t++) begin
        drive(stream_exp(a, (t % 2 == 0) ? 1 : 0, 4));
        if (t % 2 == 0) a++;
      end
    end

    do_reset();
    for (int i = 0; i < ftab.size(); i++) drive(ftab[i]);

    // Asynchronous reset in TWID at cnt=2 after one completed frame.
    do_reset();
    for (int a = 0; a < 18; a++) drive(stream_exp(a, 1, 4));
    in_valid = 1'b0;
    #1;
    chk("pre_rst_phase", int'(o_phase), 2);
    chk("pre_rst_tw_addr", int'(o_ta), 2);
    chk("pre_rst_frame_cnt", int'(o_fc), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_phase", int'(o_phase), 0);
    chk("rst_busy", int'(o_bz), 0);
    chk("rst_tw_en", int'(o_te), 0);
    chk("rst_frame_cnt", int'(o_fc), 0);
    chk("rst_in_ready", int'(o_ir), 1);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    fc_model = 16'd0;
    for (int a = 0; a < 9; a++) drive(stream_exp(a, 1, 4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
